// File: rtl/mips_fetch_stage.sv
// MIPS IF stage with IF/ID pipeline register: PC ownership, taken-BEQ redirect,
// wrong-path squash, hazard stall, and fetch/flush performance counters.
module mips_fetch_stage #(
  parameter int                     DATA_32_W = 32,
  parameter logic [DATA_32_W-1:0]   RESET_PC  = '0,
  parameter int                     PC_INC    = 4,
  parameter logic [DATA_32_W-1:0]   NOP_INSTR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  BeqValid,
  input  logic                  flush_branch,
  input  logic [DATA_32_W-1:0]  branch_target,
  output logic [DATA_32_W-1:0]  imem_addr,
  input  logic [DATA_32_W-1:0]  imem_rdata,
  output logic [DATA_32_W-1:0]  if_id_instr,
  output logic [DATA_32_W-1:0]  if_id_pc4,
  output logic                  if_id_valid,
  output logic                  pc_misalign,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           flush_cnt
);

  localparam logic [DATA_32_W-1:0] PC_STEP = DATA_32_W'(PC_INC);

  typedef struct packed {
    logic [DATA_32_W-1:0] instr;
    logic [DATA_32_W-1:0] pc4;
    logic                 valid;
  } if_id_t;

  logic [DATA_32_W-1:0] pc_q;
  logic [DATA_32_W-1:0] pc_plus;
  if_id_t               if_id_q;

  assign pc_plus   = pc_q + PC_STEP;
  assign imem_addr = pc_q;

  // A stall freezes everything; the ID stage re-presents its branch decision later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_id_q     <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
      pc_misalign <= 1'b0;
      fetch_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (!stall_if) begin
      if (BeqValid) begin
        pc_q <= {branch_target[DATA_32_W-1:2], 2'b00};
        if (|branch_target[1:0]) pc_misalign <= 1'b1;
      end else begin
        pc_q <= pc_plus;
      end
      if (flush_branch) begin
        if_id_q   <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        flush_cnt <= flush_cnt + 32'd1;
      end else begin
        if_id_q   <= '{instr: imem_rdata, pc4: pc_plus, valid: 1'b1};
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed + randomized checks of mips_fetch_stage against a rule-level reference model.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        BeqValid = 1'b0;
  logic        flush_branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid, pc_misalign;
  logic [31:0] fetch_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_flcnt;
  logic        m_valid, m_mis;

  mips_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .BeqValid(BeqValid),
    .flush_branch(flush_branch), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .pc_misalign(pc_misalign), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = tag(imem_addr);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_mis = 1'b0; m_fcnt = 32'h0; m_flcnt = 32'h0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".imem_addr"},   imem_addr,          m_pc);
    chk({ctx, ".instr"},       if_id_instr,        m_instr);
    chk({ctx, ".pc4"},         if_id_pc4,          m_pc4);
    chk({ctx, ".valid"},       32'(if_id_valid),   32'(m_valid));
    chk({ctx, ".misalign"},    32'(pc_misalign),   32'(m_mis));
    chk({ctx, ".fetch_cnt"},   fetch_cnt,          m_fcnt);
    chk({ctx, ".flush_cnt"},   flush_cnt,          m_flcnt);
  endtask

  // One clock: apply inputs, advance model by the priority rules, compare after the edge.
  task automatic cyc(input string ctx, input logic st, input logic beq, input logic fl,
                     input logic [31:0] tgt);
    stall_if = st; BeqValid = beq; flush_branch = fl; branch_target = tgt;
    if (!st) begin
      if (fl) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flcnt = m_flcnt + 1;
      end else begin
        m_instr = tag(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_fcnt = m_fcnt + 1;
      end
      if (beq) begin
        m_pc = tgt - (tgt % 4);
        if (tgt % 4 != 0) m_mis = 1'b1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Sequential fetch from reset PC
    cyc("seq0", 0, 0, 0, 0);
    cyc("seq1", 0, 0, 0, 0);
    chk("seq.fetch_cnt2", fetch_cnt, 32'd2);
    cyc("seq2", 0, 0, 0, 0);
    cyc("seq3", 0, 0, 0, 0);
    chk("pre_beq.pc", imem_addr, 32'h10);

    // Taken BEQ from 0x10 to 0x40
    cyc("beq", 0, 1, 1, 32'h40);
    chk("beq.pc", imem_addr, 32'h40);
    chk("beq.flush_cnt", flush_cnt, 32'd1);
    cyc("beq_tgt", 0, 0, 0, 0);
    chk("beq_tgt.pc4", if_id_pc4, 32'h44);

    // Stall overrides branch at pc 0x20
    cyc("to20", 0, 1, 1, 32'h20);
    cyc("stall", 1, 1, 1, 32'h80);
    chk("stall.pc", imem_addr, 32'h20);
    cyc("stall2", 1, 0, 0, 0);
    cyc("unstall", 0, 1, 1, 32'h80);

    // PC wrap
    cyc("to_top", 0, 1, 1, 32'hFFFF_FFFC);
    cyc("wrap", 0, 0, 0, 0);
    chk("wrap.pc", imem_addr, 32'h0);
    chk("wrap.pc4", if_id_pc4, 32'h0);

    // Misaligned target, sticky flag
    cyc("mis", 0, 1, 1, 32'h42);
    chk("mis.pc", imem_addr, 32'h40);
    chk("mis.flag", 32'(pc_misalign), 32'd1);
    cyc("mis_hold", 0, 1, 0, 32'h100);
    cyc("mis_hold2", 0, 0, 0, 0);

    // Flush without branch; back-to-back branches
    cyc("flush_only", 0, 0, 1, 0);
    cyc("b2b0", 0, 1, 1, 32'h200);
    cyc("b2b1", 0, 1, 1, 32'h300);
    cyc("b2b2", 0, 0, 0, 0);

    // Async reset between edges
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    #1 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic st, beq, fl;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 5) == 0);
      beq = ($urandom_range(0, 3) == 0);
      fl  = beq ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 19) != 0) tgt[1:0] = 2'b00;
      if (i == 250) tgt = 32'hFFFF_FFFC;
      cyc("rand", st, beq, fl, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
